// File: rtl/spine_switch_arbiter.sv
// Spine switching stage: per-input one-flit holding registers feeding per-output
// round-robin arbiters that honour destination FIFO-full backpressure.
module spine_switch_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int DWIDTH    = 8,
  parameter int DEST_W    = 2,
  parameter int DEST_LSB  = 6
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NUM_PORTS*DWIDTH-1:0] in_data,
  input  logic [NUM_PORTS-1:0]        in_valid,
  output logic [NUM_PORTS-1:0]        in_busy,
  input  logic [NUM_PORTS-1:0]        out_full,
  output logic [NUM_PORTS*DWIDTH-1:0] out_data,
  output logic [NUM_PORTS-1:0]        out_valid,
  output logic [NUM_PORTS-1:0]        in_ovf,
  output logic                        bad_dest
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [DEST_W:0] NP = (DEST_W+1)'(NUM_PORTS);

  logic [DWIDTH-1:0]    hold_data_p0 [NUM_PORTS];
  logic [NUM_PORTS-1:0] hold_vld_p0;
  logic [DEST_W-1:0]    dest_p0 [NUM_PORTS];
  logic [NUM_PORTS-1:0] bad_p0;
  logic [NUM_PORTS-1:0] leave_p0;
  logic [NUM_PORTS-1:0] capture_p0;
  logic [NUM_PORTS-1:0] ovf_q;
  logic [PW-1:0]        ptr [NUM_PORTS];
  logic [NUM_PORTS-1:0] gnt_vld;
  logic [PW-1:0]        gnt_idx [NUM_PORTS];
  logic [NUM_PORTS-1:0] in_gnt;
  logic [DWIDTH-1:0]    out_data_p1 [NUM_PORTS];
  logic [NUM_PORTS-1:0] out_vld_p1;
  logic                 bad_dest_p1;

  always_comb begin
    bad_p0     = '0;
    leave_p0   = '0;
    capture_p0 = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      dest_p0[i]    = hold_data_p0[i][DEST_LSB +: DEST_W];
      bad_p0[i]     = hold_vld_p0[i] && ({1'b0, dest_p0[i]} >= NP);
      leave_p0[i]   = in_gnt[i] || bad_p0[i];
      capture_p0[i] = in_valid[i] && (!hold_vld_p0[i] || leave_p0[i]);
    end
  end

  // Round-robin: lowest requester at/above ptr wins, else lowest requester overall.
  always_comb begin
    logic          hit_hi;
    logic          hit_lo;
    logic [PW-1:0] idx_hi;
    logic [PW-1:0] idx_lo;
    gnt_vld = '0;
    in_gnt  = '0;
    hit_hi  = 1'b0;
    hit_lo  = 1'b0;
    idx_hi  = '0;
    idx_lo  = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      gnt_idx[j] = '0;
      hit_hi     = 1'b0;
      hit_lo     = 1'b0;
      idx_hi     = '0;
      idx_lo     = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (hold_vld_p0[i] && (dest_p0[i] == DEST_W'(j))) begin
          hit_lo = 1'b1;
          idx_lo = PW'(i);
          if (PW'(i) >= ptr[j]) begin
            hit_hi = 1'b1;
            idx_hi = PW'(i);
          end
        end
      end
      gnt_vld[j] = hit_lo && !out_full[j];
      gnt_idx[j] = hit_hi ? idx_hi : idx_lo;
    end
    for (int j = 0; j < NUM_PORTS; j++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (gnt_vld[j] && (gnt_idx[j] == PW'(i))) in_gnt[i] = 1'b1;
      end
    end
  end

  // Stage p0: holding registers (data path carries no reset)
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (capture_p0[i]) hold_data_p0[i] <= in_data[i*DWIDTH +: DWIDTH];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_vld_p0 <= '0;
      ovf_q       <= '0;
      out_vld_p1  <= '0;
      bad_dest_p1 <= 1'b0;
      for (int j = 0; j < NUM_PORTS; j++) begin
        ptr[j]         <= '0;
        out_data_p1[j] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (capture_p0[i])    hold_vld_p0[i] <= 1'b1;
        else if (leave_p0[i]) hold_vld_p0[i] <= 1'b0;
        if (in_valid[i] && hold_vld_p0[i] && !leave_p0[i]) ovf_q[i] <= 1'b1;
      end
      // Stage p1: routed outputs and pointer advance
      for (int j = 0; j < NUM_PORTS; j++) begin
        out_vld_p1[j] <= gnt_vld[j];
        if (gnt_vld[j]) begin
          out_data_p1[j] <= hold_data_p0[gnt_idx[j]];
          ptr[j]         <= (gnt_idx[j] == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx[j] + 1'b1;
        end
      end
      bad_dest_p1 <= |bad_p0;
    end
  end

  always_comb begin
    out_data = '0;
    for (int j = 0; j < NUM_PORTS; j++) out_data[j*DWIDTH +: DWIDTH] = out_data_p1[j];
  end

  assign out_valid = out_vld_p1;
  assign in_busy   = hold_vld_p0;
  assign in_ovf    = ovf_q;
  assign bad_dest  = bad_dest_p1;

endmodule

// File: tb/tb_spine_switch_arbiter.sv
// Scoreboard bench for spine_switch_arbiter: per-output expected-flit queues plus
// directed timing checks; a second 3-port instance covers out-of-range destinations.
module tb_spine_switch_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_busy, out_full, out_valid, in_ovf;
  logic [31:0] out_data;
  logic        bad_dest;

  logic [23:0] d3_in_data, d3_out_data;
  logic [2:0]  d3_in_valid, d3_in_busy, d3_out_full, d3_out_valid, d3_in_ovf;
  logic        d3_bad_dest;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q [4][$];

  always #5 clk = ~clk;

  spine_switch_arbiter #(.NUM_PORTS(4), .DWIDTH(8), .DEST_W(2), .DEST_LSB(6)) u_dut (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .in_busy(in_busy),
    .out_full(out_full), .out_data(out_data), .out_valid(out_valid), .in_ovf(in_ovf),
    .bad_dest(bad_dest));

  spine_switch_arbiter #(.NUM_PORTS(3), .DWIDTH(8), .DEST_W(2), .DEST_LSB(6)) u_dut3 (
    .clk(clk), .rstn(rstn), .in_data(d3_in_data), .in_valid(d3_in_valid), .in_busy(d3_in_busy),
    .out_full(d3_out_full), .out_data(d3_out_data), .out_valid(d3_out_valid), .in_ovf(d3_in_ovf),
    .bad_dest(d3_bad_dest));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every delivered flit must match the oldest expected one on that output.
  always @(negedge clk) begin : mon
    logic [7:0] e;
    if (rstn) begin
      for (int j = 0; j < 4; j++) begin
        if (out_valid[j]) begin
          if (exp_q[j].size() == 0) begin
            chk($sformatf("spurious_out%0d", j), 32'(out_data[j*8 +: 8]), 32'hFFFF_FFFF);
          end else begin
            e = exp_q[j].pop_front();
            chk($sformatf("sb_out%0d", j), 32'(out_data[j*8 +: 8]), 32'(e));
          end
        end
      end
    end
  end

  initial begin
    rstn = 1'b0; in_data = '0; in_valid = '0; out_full = '0;
    d3_in_data = '0; d3_in_valid = '0; d3_out_full = '0;
    tick(3);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_busy",   32'(in_busy),   32'h0);
    chk("rst_in_ovf",    32'(in_ovf),    32'h0);
    chk("rst_bad_dest",  32'(bad_dest),  32'h0);
    chk("rst_out_data",  out_data,       32'h0);
    rstn = 1'b1;
    tick();

    // Single flit in0 -> dest 1
    in_data[7:0] = 8'h45; in_valid = 4'b0001; exp_q[1].push_back(8'h45);
    tick(); in_valid = '0;
    chk("t1_busy",     32'(in_busy),   32'b0001);
    chk("t1_early",    32'(out_valid), 32'h0);
    tick();
    chk("t1_valid",    32'(out_valid), 32'b0010);
    chk("t1_data",     32'(out_data[15:8]), 32'h45);
    chk("t1_busy_clr", 32'(in_busy),   32'h0);
    tick();
    chk("t1_pulse",    32'(out_valid), 32'h0);

    // Four-way contention on dest 2
    for (int i = 0; i < 4; i++) begin
      in_data[i*8 +: 8] = 8'(32'h80 + i);
      exp_q[2].push_back(8'(32'h80 + i));
    end
    in_valid = 4'hF;
    tick(); in_valid = '0;
    chk("t2_busy", 32'(in_busy), 32'hF);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t2_valid%0d", k), 32'(out_valid), 32'b0100);
      chk($sformatf("t2_order%0d", k), 32'(out_data[23:16]), 32'h80 + k);
    end
    tick();
    chk("t2_done", 32'(out_valid), 32'h0);
    chk("t2_idle", 32'(in_busy), 32'h0);
    // Pointer wrapped to 0: in1 beats in3
    in_data[15:8] = 8'h81; in_data[31:24] = 8'h83; in_valid = 4'b1010;
    exp_q[2].push_back(8'h81); exp_q[2].push_back(8'h83);
    tick(); in_valid = '0;
    tick(); chk("t2_wrap0", 32'(out_data[23:16]), 32'h81);
    tick(); chk("t2_wrap1", 32'(out_data[23:16]), 32'h83);
    tick();

    // Backpressure on dest 3
    out_full = 4'b1000;
    in_data[23:16] = 8'hC2; in_valid = 4'b0100; exp_q[3].push_back(8'hC2);
    tick(); in_valid = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_blocked", 32'(out_valid[3]), 32'h0);
      chk("t3_busy",    32'(in_busy[2]),   32'h1);
    end
    out_full = '0;
    tick();
    chk("t3_valid", 32'(out_valid), 32'b1000);
    chk("t3_data",  32'(out_data[31:24]), 32'hC2);
    tick();

    // Overflow while blocked
    out_full = 4'b1000;
    in_data[7:0] = 8'hC1; in_valid = 4'b0001; exp_q[3].push_back(8'hC1);
    tick();
    in_data[7:0] = 8'hC9;
    tick(); in_valid = '0;
    chk("t4_ovf",  32'(in_ovf),  32'b0001);
    chk("t4_busy", 32'(in_busy), 32'b0001);
    tick(3);
    chk("t4_ovf_sticky", 32'(in_ovf), 32'b0001);
    out_full = '0;
    tick();
    chk("t4_valid", 32'(out_valid), 32'b1000);
    chk("t4_data",  32'(out_data[31:24]), 32'hC1);
    tick();
    chk("t4_no_second", 32'(out_valid), 32'h0);
    chk("t4_ovf_hold",  32'(in_ovf), 32'b0001);

    // Three-port instance: out-of-range destination and parallel delivery
    d3_in_data[7:0] = 8'hC0; d3_in_valid = 3'b001;
    tick(); d3_in_valid = '0;
    chk("t5_busy",     32'(d3_in_busy),  32'b001);
    chk("t5_bad_pre",  32'(d3_bad_dest), 32'h0);
    tick();
    chk("t5_bad",      32'(d3_bad_dest),  32'h1);
    chk("t5_busy_clr", 32'(d3_in_busy),   32'h0);
    chk("t5_no_out",   32'(d3_out_valid), 32'h0);
    tick();
    chk("t5_bad_pulse", 32'(d3_bad_dest), 32'h0);
    d3_in_data[7:0] = 8'h05; d3_in_data[15:8] = 8'h47; d3_in_valid = 3'b011;
    tick(); d3_in_valid = '0;
    tick();
    chk("t5_par_valid", 32'(d3_out_valid), 32'b011);
    chk("t5_par_d0",    32'(d3_out_data[7:0]),  32'h05);
    chk("t5_par_d1",    32'(d3_out_data[15:8]), 32'h47);

    // Async reset with blocked flits held
    out_full = 4'hF;
    in_data[7:0] = 8'h41; in_data[15:8] = 8'h81; in_data[23:16] = 8'hC2; in_valid = 4'b0111;
    tick(); in_valid = '0;
    chk("t6_held", 32'(in_busy), 32'b0111);
    tick();
    #2 rstn = 1'b0;
    #1;
    chk("t6_busy",     32'(in_busy),   32'h0);
    chk("t6_valid",    32'(out_valid), 32'h0);
    chk("t6_data",     out_data,       32'h0);
    chk("t6_ovf",      32'(in_ovf),    32'h0);
    chk("t6_d3_data",  32'(d3_out_data), 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1; out_full = '0;
    tick(6);
    chk("t6_no_stale", 32'(in_busy), 32'h0);

    for (int j = 0; j < 4; j++) chk($sformatf("q_left%0d", j), 32'(exp_q[j].size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spine_switch_arbiter.md
Name: spine_switch_arbiter

Overview:
- Switching stage directly downstream of the spine router ports.
- Takes the per-port outgoing flit streams (data/valid pulses) from NUM_PORTS ports and routes each single-flit packet to the output named by the destination field in the flit.
- Uses per-output round-robin arbitration and honours each destination port's FIFO-full backpressure.
- Each input has a one-entry holding register, so a port with no ready handshake sees a simple busy flag.

Parameters:
- NUM_PORTS, 4, number of input and output ports (2..8).
- DWIDTH, 8, flit width in bits.
- DEST_W, 2, destination field width. Requires NUM_PORTS <= 2**DEST_W.
- DEST_LSB, 6, bit position of the destination field: dest = flit[DEST_LSB +: DEST_W]. Requires DEST_LSB+DEST_W <= DWIDTH.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- in_data  input  NUM_PORTS*DWIDTH  flits from the ports; port i occupies bits [i*DWIDTH +: DWIDTH].
- in_valid  input  NUM_PORTS  one-cycle flit-valid per input.
- in_busy  output  NUM_PORTS  holding register i occupied; upstream must not assert in_valid[i].
- out_full  input  NUM_PORTS  destination j cannot accept a flit (its FIFO is full).
- out_data  output  NUM_PORTS*DWIDTH  routed flit per output; output j occupies bits [j*DWIDTH +: DWIDTH].
- out_valid  output  NUM_PORTS  one-cycle flit-valid per output.
- in_ovf  output  NUM_PORTS  sticky: a flit arrived on input i while its holding register was occupied and not being drained.
- bad_dest  output  1  one-cycle pulse: a flit with dest >= NUM_PORTS was discarded.

Behaviour:
- Reset (rstn=0, async):
  - All hold_vld=0, all round-robin pointers ptr[j]=0.
  - out_data=0, out_valid=0, in_ovf=0, bad_dest=0.
  - in_busy=0, because it is driven from hold_vld.
  - Any flit held at reset is discarded.
- Holding register per input i:
  - in_busy[i] = hold_vld[i], driven directly from the register with no combinational path from inputs.
  - Capture at the edge when in_valid[i] && (!hold_vld[i] || grant_i), where grant_i means the held flit leaves this cycle (back-to-back refill allowed).
  - If in_valid[i] && hold_vld[i] && !grant_i: the new flit is dropped, the held flit is kept, and in_ovf[i] is set (cleared only by reset).
  - Otherwise hold_vld[i] clears when granted or discarded.
- Decode and discard:
  - dest_i = hold_data[i][DEST_LSB +: DEST_W].
  - If hold_vld[i] && dest_i >= NUM_PORTS: the flit is discarded at the next edge and bad_dest pulses high for one cycle after that edge. The OR over all inputs gives a single pulse.
- Arbitration per output j, combinational on the registered state:
  - req_j[i] = hold_vld[i] && dest_i==j.
  - If out_full[j]=0 and req_j is nonzero: grant the first requester at or after ptr[j], searching upward with modulo NUM_PORTS wrap.
  - At the edge: out_data[j] <= hold_data[g], out_valid[j] <= 1, ptr[j] <= (g+1) mod NUM_PORTS.
  - Otherwise: out_valid[j] <= 0, ptr[j] unchanged, out_data[j] holds its last value.
  - out_full is sampled in the arbitration cycle; a blocked flit waits in hold indefinitely with no drop.
- Concurrency:
  - Distinct outputs arbitrate independently, so up to NUM_PORTS flits move per cycle.
  - An input holds one flit, so it has at most one grant per cycle.
  - dest == source is legal (loopback).
- Latency: in_valid[i] sampled at edge E0 → hold_vld after E0 → out_valid[dest] high for exactly the cycle after E1 when unblocked (2 edges).
- Throughput: with continuous grants, one flit per input per cycle via the refill path.
- Fairness: with N inputs contending for one unblocked output, each input is granted exactly once in every N consecutive grants.

Test Plan:
- Reset then single flit 8'b01_000101 on in0 (dest 1) → out_valid[1] pulses the 2nd cycle after injection with out_data[1]=8'h45; in_busy[0] high for 1 cycle; all other outputs 0.
- Inputs 0,1,2,3 each hold a flit to dest 2 simultaneously, out_full=0 → out_valid[2] high 4 consecutive cycles, grant order 0,1,2,3; next contention round starts at ptr=0 after wrap.
- out_full[3]=1 for 5 cycles with a flit held for dest 3 → no out_valid[3]; in_busy stays 1; flit delivered unchanged the cycle after out_full drops.
- in0 gets a flit (dest 3, out_full[3]=1), then in_valid[0] again while busy → in_ovf[0]=1 sticky; only the first flit is delivered after out_full clears.
- NUM_PORTS=3, DEST_W=2: flit with dest=3 → bad_dest one-cycle pulse, no out_valid, in_busy clears; in0 dest0 and in1 dest1 in the same cycle → both delivered the same cycle.
- rstn pulled low while 3 flits are held and out_full=all ones → all outputs and in_busy go 0 immediately; after release no stale flit appears on any output.
